// File: rtl/leb128_encoder.sv
// leb128_encoder
// ---------------------------------------------------------------------------
// Streams one 32- or 64-bit integer per transaction as a WebAssembly LEB128
// byte sequence (ULEB128 or SLEB128), one byte per clock.
//
// Parameter
//   USE_64B   : 1 = 32- and 64-bit operands; 0 = 32-bit only (in_is64 and
//               in_value[63:32] are ignored)
//
// Optional build macro
//   LEB128_ENC_PAD_EN : adds in_pad. When a value is accepted with in_pad=1
//               it is emitted in padded form, always 5 (i32) or 10 (i64) bytes.
//
// Ports
//   clk        clock, all logic on the rising edge
//   reset      synchronous, active-high
//   in_valid   value offered
//   in_ready   encoder idle and able to accept a value
//   in_value   operand; only [31:0] is used for i32
//   in_signed  1 = SLEB128, 0 = ULEB128
//   in_is64    1 = i64 operand, 0 = i32
//   in_pad     (LEB128_ENC_PAD_EN only) request the padded form
//   out_valid  out_byte is valid
//   out_ready  sink accepts the byte
//   out_byte   {continuation, payload[6:0]}
//   out_last   current byte is the last byte of the value
//   out_count  0-based index of the current byte within the value
//   busy       encoding in progress (inverse of in_ready)
// ---------------------------------------------------------------------------
module leb128_encoder #(
    parameter bit USE_64B = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_value,
    input  logic        in_signed,
    input  logic        in_is64,
`ifdef LEB128_ENC_PAD_EN
    input  logic        in_pad,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic        out_last,
    output logic [3:0]  out_count,
    output logic        busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] work_q, work_d;
    logic        signed_q, signed_d;
    logic [3:0]  count_q, count_d;
`ifdef LEB128_ENC_PAD_EN
    logic        pad_q, pad_d;
    logic        is64_q, is64_d;
    logic [3:0]  last_idx;
`endif

    logic        accept_is64;
    logic [63:0] accept_value;
    logic        upper_zero;
    logic        upper_ones;
    logic        natural_term;
    logic        term;
    logic [63:0] work_shifted;

    // Operand width/extension resolved at accept so the emit path only ever
    // sees a 64-bit register; i32 values are sign- or zero-extended so the
    // same termination test works for both widths.
    always_comb begin
        accept_is64 = USE_64B && in_is64;
        if (accept_is64) begin
            accept_value = in_value;
        end else if (in_signed) begin
            accept_value = {{32{in_value[31]}}, in_value[31:0]};
        end else begin
            accept_value = {32'h0, in_value[31:0]};
        end
    end

    // Termination looks at what would remain after this byte: nothing left
    // (unsigned), or only sign bits that agree with payload bit 6 (signed).
    always_comb begin
        upper_zero   = ~|work_q[63:7];
        upper_ones   = &work_q[63:7];
        natural_term = signed_q ? ((upper_zero && !work_q[6]) || (upper_ones && work_q[6]))
                                : upper_zero;
`ifdef LEB128_ENC_PAD_EN
        last_idx = is64_q ? 4'd9 : 4'd4;
        // Padded form: always run to the maximum length. By that index the
        // natural test is guaranteed true, so the stream stays well formed.
        term     = pad_q ? (count_q == last_idx) : natural_term;
`else
        term     = natural_term;
`endif
        work_shifted = signed_q ? {{7{work_q[63]}}, work_q[63:7]}
                                : {7'h00, work_q[63:7]};
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        signed_d = signed_q;
        count_d  = count_q;
`ifdef LEB128_ENC_PAD_EN
        pad_d    = pad_q;
        is64_d   = is64_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d   = accept_value;
                    signed_d = in_signed;
                    count_d  = 4'd0;
`ifdef LEB128_ENC_PAD_EN
                    pad_d    = in_pad;
                    is64_d   = accept_is64;
`endif
                    state_d  = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (term) begin
                        state_d = ST_IDLE;
                        count_d = 4'd0;
                    end else begin
                        work_d  = work_shifted;
                        count_d = count_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            work_q   <= 64'h0;
            signed_q <= 1'b0;
            count_q  <= 4'd0;
`ifdef LEB128_ENC_PAD_EN
            pad_q    <= 1'b0;
            is64_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            signed_q <= signed_d;
            count_q  <= count_d;
`ifdef LEB128_ENC_PAD_EN
            pad_q    <= pad_d;
            is64_q   <= is64_d;
`endif
        end
    end

    // Outputs decode registered state only; while stalled nothing they depend
    // on changes, so the byte is held stable for the sink.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        busy      = (state_q == ST_EMIT);
        out_valid = (state_q == ST_EMIT);
        out_byte  = (state_q == ST_EMIT) ? {!term, work_q[6:0]} : 8'h00;
        out_last  = (state_q == ST_EMIT) && term;
        out_count = count_q;
    end

endmodule

// File: doc/leb128_encoder.md
Name: leb128_encoder

Overview:
Streams a 32- or 64-bit integer as a WebAssembly LEB128 byte sequence, signed or unsigned, one byte per cycle. It is the encoder counterpart of the CPU's immediate-decoding path.
Used by the test infrastructure and the result-dump path to produce byte images the CPU fetch path consumes.
Valid/ready on both input and output sides.

Parameters:
USE_64B, 1, when 0 only 32-bit encoding exists; in_is64 ignored (treated 0), in_value[63:32] ignored.

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
in_valid  input  1  value offered
in_ready  output  1  encoder idle, accepts value
in_value  input  64  value; only [31:0] used when 32-bit
in_signed  input  1  1 = SLEB128, 0 = ULEB128
in_is64  input  1  1 = i64 operand, 0 = i32
out_valid  output  1  out_byte valid
out_ready  input  1  sink accepts byte
out_byte  output  8  {continuation bit, 7 payload bits}
out_last  output  1  current byte is final byte of value (continuation bit 0)
out_count  output  4  0-based index of current byte within value
busy  output  1  encoding in progress (== !in_ready)

Behaviour:
- Reset (sync, priority over everything): state IDLE, in_ready=1, out_valid=0, out_byte=0, out_last=0, out_count=0, busy=0 on the cycle after reset is sampled. Handshakes in a reset cycle are ignored. Reset mid-emission aborts the value; no further bytes are emitted.
- States: IDLE, EMIT.
- IDLE: in_ready=1.
  - On in_valid&&in_ready, latch a 64-bit work register. 32-bit mode: low 32 bits, sign-extended if in_signed, else zero-extended.
  - Also latch the signed flag. Go to EMIT.
  - First byte valid the next cycle (1-cycle latency); out_count=0.
- EMIT: in_ready=0.
  - out_byte[6:0]=work[6:0].
  - Termination, unsigned: (work>>7)==0.
  - Termination, signed: ((work>>>7)==0 && work[6]==0) || ((work>>>7)==all-ones && work[6]==1).
  - out_byte[7]=!term; out_last=term.
- Output handshake: byte transfers on out_valid&&out_ready.
  - Non-last byte: shift work right 7 (arithmetic if signed, logical otherwise); out_count+1; next byte valid the next cycle.
  - Last byte: go IDLE; in_ready=1 the next cycle.
- Throughput: one byte/cycle with out_ready held 1; one bubble cycle between values.
- Backpressure: out_byte, out_last, out_count are held stable while out_valid && !out_ready.
- Max length: 5 bytes (32-bit), 10 bytes (64-bit). out_count never exceeds 9.
- in_value, in_signed, in_is64 are sampled only at accept; later changes have no effect.
- All outputs are registered or decoded only from registered state; no combinational in→out path.

Optional Feature:
LEB128_ENC_PAD_EN.
- Defined: adds port in_pad (input, 1), latched at accept. When 1, natural termination is suppressed until out_count == max-1 (4 or 9). Intermediate bytes carry continuation=1, payload from the shifted work register, giving the canonical padded form. Example: 0 → 80 80 80 80 00; signed -1 → FF FF FF FF 7F.
- Undefined: port absent; minimal-length encoding only.

Test Plan:
- Unsigned 32-bit 624485, out_ready=1 → E5 8E 26; out_last on 3rd byte; out_count 0,1,2; in_ready back to 1 the cycle after.
- Signed 32-bit -123456 → C0 BB 78. Signed 0 → 00. Signed -1 → 7F. Signed 63 → 3F. Signed 64 → C0 00. Signed -64 → 40. Each single-value run shows correct out_last.
- Unsigned 64-bit 0xFFFF_FFFF_FFFF_FFFF → FF×9 then 01 (10 bytes, out_count 9 on last). Unsigned 32-bit with in_value=0xDEADBEEF_FFFFFFFF → FF FF FF FF 0F (upper bits ignored).
- Backpressure: 624485 with out_ready pattern 0,1,0,0,1,1 → each byte held stable while stalled, sequence unchanged. in_valid held high during EMIT → no second accept until after the last byte.
- Reset asserted one cycle while 2nd byte pending → next cycle out_valid=0, in_ready=1. A following value 5 encodes as single byte 05.
- With LEB128_ENC_PAD_EN, in_pad=1: unsigned 32-bit 0 → 80 80 80 80 00. Signed -1 → FF FF FF FF 7F. 64-bit unsigned 1 → 81 80×8 00.
